// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - opcodes, reply bytes and FSM state encoding for the UART memory bridge
//
// Purpose : shared constants and enumerations imported by uart_mem_bridge.
// Contents: OPC_WRITE / OPC_READ request opcodes, OPC_ACK / OPC_ERR reply
//           bytes, state_t (bridge FSM states) and op_t (decoded command).
package uart_bridge_pkg;

  localparam logic [7:0] OPC_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OPC_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OPC_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] OPC_ERR   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_TX
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE,
    OP_READ,
    OP_BAD
  } op_t;

endpackage

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - byte-serial UART command bridge to a 32-bit memory port
//
// Purpose : decodes 'W' addr[4] data[4] / 'R' addr[4] commands from a UART
//           receiver, performs one memory access and replies 'K', four read
//           data bytes (MSB first) or '?' for an unknown opcode.
// Ports   : clk, rst (sync, active-high)
//           uart_full/uart_dout/uart_re   - receive side, uart_re pops a byte
//           uart_empty/uart_we/uart_din   - transmit side, uart_we starts a byte
//           mem_addr/mem_wdata/mem_we/mem_re/mem_ready/mem_rdata - memory port
//           busy                          - high whenever the FSM is not idle
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_full,
  input  logic [7:0]  uart_dout,
  output logic        uart_re,
  input  logic        uart_empty,
  output logic        uart_we,
  output logic [7:0]  uart_din,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int TW = ($clog2(TIMEOUT_CLKS) < 1) ? 1 : $clog2(TIMEOUT_CLKS);

  state_t          state;
  op_t             op;
  logic [1:0]      byte_idx;   // operand byte index, reused as reply byte index
  logic [31:0]     rdata_q;
  logic [TW-1:0]   tout;
  logic            rx_gap;
  logic            tx_gap;
  logic            take;
  logic            tx_last;
  logic [7:0]      tx_byte;

  // A byte is only taken when neither the pop pulse nor the cycle after it is
  // active, so the UART has time to update uart_full/uart_dout.
  assign take = uart_full && !uart_re && !rx_gap;
  assign busy = (state != ST_IDLE);

  always_comb begin
    tx_byte = OPC_ACK;
    tx_last = 1'b1;
    case (op)
      OP_READ: begin
        tx_last = (byte_idx == 2'd3);
        case (byte_idx)
          2'd0:    tx_byte = rdata_q[31:24];
          2'd1:    tx_byte = rdata_q[23:16];
          2'd2:    tx_byte = rdata_q[15:8];
          default: tx_byte = rdata_q[7:0];
        endcase
      end
      OP_BAD:  tx_byte = OPC_ERR;
      default: tx_byte = OPC_ACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= OP_BAD;
      byte_idx  <= 2'd0;
      rdata_q   <= 32'h0;
      tout      <= '0;
      rx_gap    <= 1'b0;
      tx_gap    <= 1'b0;
      uart_re   <= 1'b0;
      uart_we   <= 1'b0;
      uart_din  <= 8'h00;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      uart_re <= 1'b0;
      uart_we <= 1'b0;
      rx_gap  <= uart_re;
      tx_gap  <= uart_we;
      case (state)
        ST_IDLE: begin
          if (take) begin
            uart_re  <= 1'b1;
            byte_idx <= 2'd0;
            tout     <= '0;
            if (uart_dout == OPC_WRITE) begin
              op    <= OP_WRITE;
              state <= ST_ADDR;
            end else if (uart_dout == OPC_READ) begin
              op    <= OP_READ;
              state <= ST_ADDR;
            end else begin
              op    <= OP_BAD;
              state <= ST_TX;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (take) begin
            uart_re  <= 1'b1;
            tout     <= '0;
            byte_idx <= byte_idx + 2'd1;
            // Operands shift in from the LSB so the first byte ends up in 31:24.
            if (state == ST_ADDR) mem_addr  <= {mem_addr[23:0], uart_dout};
            else                  mem_wdata <= {mem_wdata[23:0], uart_dout};
            if (byte_idx == 2'd3) begin
              if (state == ST_DATA) begin
                mem_we <= 1'b1;
                state  <= ST_MEM;
              end else if (op == OP_WRITE) begin
                state <= ST_DATA;
              end else begin
                mem_re <= 1'b1;
                state  <= ST_MEM;
              end
            end
          end else if (tout == TW'(TIMEOUT_CLKS - 1)) begin
            // Abandon the command silently; the next command reloads all operands.
            state <= ST_IDLE;
          end else begin
            tout <= tout + TW'(1);
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            byte_idx <= 2'd0;
            state    <= ST_TX;
            if (mem_re) rdata_q <= mem_rdata;
          end
        end
        ST_TX: begin
          if (uart_empty && !uart_we && !tx_gap) begin
            uart_we  <= 1'b1;
            uart_din <= tx_byte;
            if (tx_last) state <= ST_IDLE;
            else         byte_idx <= byte_idx + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - self-checking bench for uart_mem_bridge with UART/memory models
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_full;
  logic [7:0]  uart_dout;
  logic        uart_re;
  logic        uart_empty;
  logic        uart_we;
  logic [7:0]  uart_din;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  uart_mem_bridge #(.TIMEOUT_CLKS(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_full  (uart_full),
    .uart_dout  (uart_dout),
    .uart_re    (uart_re),
    .uart_empty (uart_empty),
    .uart_we    (uart_we),
    .uart_din   (uart_din),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_s;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  act_tx[$];
  logic [7:0]  exp_tx[$];
  op_s         act_ops[$];
  op_s         exp_ops[$];
  logic [31:0] dev_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int          pops = 0;
  int          mem_delay = 1;
  int          req_cycles = 0;
  int          last_held = 0;
  logic        req_we = 1'b0;
  logic        req_unstable = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  int          tx_busy_cycles = 0;
  int          tx_cnt = 0;
  bit          tx_hold = 1'b0;
  logic        prev_empty = 1'b1;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] dev_word(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // UART and memory models: observe DUT outputs 1 time unit after each edge.
  initial begin
    uart_full  = 1'b0;
    uart_dout  = 8'h00;
    uart_empty = 1'b1;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      prev_empty = uart_empty;
      if (rst) begin
        req_cycles = 0;
        tx_cnt     = 0;
        prev_we    = 1'b0;
      end else begin
        if (uart_re) begin
          if (rx_q.size() == 0) check("uart_re_without_byte", 32'd1, 32'd0);
          else begin
            void'(rx_q.pop_front());
            pops++;
          end
        end
        if (uart_we) begin
          check("uart_we_while_tx_busy", {31'd0, prev_empty}, 32'd1);
          check("uart_we_back_to_back", {31'd0, prev_we}, 32'd0);
          act_tx.push_back(uart_din);
          tx_cnt = tx_busy_cycles;
        end else if (tx_cnt > 0) begin
          tx_cnt--;
        end
        prev_we = uart_we;
        if (mem_we || mem_re) begin
          if (req_cycles == 0) begin
            check("mem_req_one_hot", {31'd0, mem_we & mem_re}, 32'd0);
            req_we       = mem_we;
            req_addr     = mem_addr;
            req_wdata    = mem_wdata;
            req_unstable = 1'b0;
          end else if (mem_addr !== req_addr || mem_wdata !== req_wdata) begin
            req_unstable = 1'b1;
          end
          req_cycles++;
        end else if (req_cycles > 0) begin
          op_s o;
          o.we   = req_we;
          o.addr = req_addr;
          o.data = req_we ? req_wdata : dev_word(req_addr);
          if (req_we) dev_mem[req_addr] = req_wdata;
          act_ops.push_back(o);
          check("mem_operands_stable", {31'd0, req_unstable}, 32'd0);
          last_held  = req_cycles;
          req_cycles = 0;
        end
      end
      uart_full  = (rx_q.size() > 0);
      uart_dout  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      uart_empty = !tx_hold && (tx_cnt == 0);
      mem_ready  = (req_cycles > 0) && (req_cycles >= mem_delay);
      mem_rdata  = (mem_ready && mem_re) ? dev_word(mem_addr) : $urandom;
    end
  end

  task automatic push_word(input logic [31:0] w);
    rx_q.push_back(w[31:24]);
    rx_q.push_back(w[23:16]);
    rx_q.push_back(w[15:8]);
    rx_q.push_back(w[7:0]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    op_s o;
    rx_q.push_back(8'h57);
    push_word(a);
    push_word(d);
    o.we = 1'b1; o.addr = a; o.data = d;
    exp_ops.push_back(o);
    ref_mem[a] = d;
    exp_tx.push_back(8'h4B);
  endtask

  task automatic send_read(input logic [31:0] a);
    op_s o;
    logic [31:0] w;
    rx_q.push_back(8'h52);
    push_word(a);
    w = ref_word(a);
    o.we = 1'b0; o.addr = a; o.data = w;
    exp_ops.push_back(o);
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic send_bad(input logic [7:0] b);
    rx_q.push_back(b);
    exp_tx.push_back(8'h3F);
  endtask

  task automatic wait_quiet(input string tag);
    int quiet = 0;
    for (int i = 0; i < 4000 && quiet < 3; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !busy && !mem_we && !mem_re) quiet++;
      else quiet = 0;
    end
    check({tag, "_done"}, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_tx_count"}, act_tx.size(), exp_tx.size());
    n = (act_tx.size() < exp_tx.size()) ? act_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check({tag, "_tx_byte"}, {24'd0, act_tx[i]}, {24'd0, exp_tx[i]});
    check({tag, "_mem_count"}, act_ops.size(), exp_ops.size());
    n = (act_ops.size() < exp_ops.size()) ? act_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_mem_we"},   {31'd0, act_ops[i].we}, {31'd0, exp_ops[i].we});
      check({tag, "_mem_addr"}, act_ops[i].addr, exp_ops[i].addr);
      check({tag, "_mem_data"}, act_ops[i].data, exp_ops[i].data);
    end
    act_tx.delete();
    exp_tx.delete();
    act_ops.delete();
    exp_ops.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_re"},   {31'd0, uart_re}, 32'd0);
    check({tag, "_uart_we"},   {31'd0, uart_we}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we},  32'd0);
    check({tag, "_mem_re"},    {31'd0, mem_re},  32'd0);
    check({tag, "_busy"},      {31'd0, busy},    32'd0);
    check({tag, "_uart_din"},  {24'd0, uart_din}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr,  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int ok;
    logic [31:0] pool [4];
    logic [7:0]  b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed write
    mem_delay = 1;
    send_write(32'h0000_1000, 32'hDEAD_BEEF);
    wait_quiet("write");
    check("write_bytes_consumed", pops, 9);
    compare("write");

    // Directed read with a slow memory and a slow transmitter
    dev_mem[32'h0000_1004] = 32'h1234_5678;
    ref_mem[32'h0000_1004] = 32'h1234_5678;
    mem_delay = 5;
    tx_busy_cycles = 8;
    send_read(32'h0000_1004);
    wait_quiet("read");
    check("read_mem_re_held", last_held, 5);
    compare("read");

    // Unknown opcode
    send_bad(8'h41);
    wait_quiet("bad");
    check("bad_busy", {31'd0, busy}, 32'd0);
    compare("bad");

    // Timeout of a partial command, then a normal read
    mem_delay = 2;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0) ok = 1;
    end
    check("timeout_bytes_taken", ok, 1);
    repeat (60) @(negedge clk);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    send_read(32'h0000_0008);
    wait_quiet("timeout_read");
    compare("timeout");

    // Reset while a write request is held
    mem_delay = 1000;
    rx_q.push_back(8'h57);
    push_word(32'h0000_2000);
    push_word(32'hCAFE_F00D);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mem_we) ok = 1;
    end
    check("rstreq_mem_we_seen", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstreq");
    rst = 1'b0;
    mem_delay = 2;
    repeat (3) @(negedge clk);
    check("rstreq_no_completion", act_ops.size(), 0);
    send_read(32'h0000_2000);
    wait_quiet("rstreq_read");
    compare("rstreq");

    // Back-to-back W then R while the transmitter is held busy
    p0 = pops;
    tx_hold = 1'b1;
    tx_busy_cycles = 3;
    send_write(32'h0000_3000, $urandom);
    send_read(32'h0000_3000);
    repeat (60) @(negedge clk);
    check("b2b_held_no_tx", act_tx.size(), 0);
    tx_hold = 1'b0;
    wait_quiet("b2b");
    check("b2b_bytes_consumed", pops - p0, 14);
    compare("b2b");

    // Randomized command stream
    pool[0] = 32'h0000_0000;
    pool[1] = 32'hFFFF_FFFC;
    pool[2] = $urandom;
    pool[3] = $urandom;
    for (int it = 0; it < 24; it++) begin
      int ncmd;
      mem_delay = $urandom_range(1, 6);
      tx_busy_cycles = $urandom_range(0, 10);
      ncmd = $urandom_range(1, 2);
      for (int c = 0; c < ncmd; c++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 3)] : $urandom;
        case ($urandom_range(0, 4))
          0, 1: send_write(a, $urandom);
          2, 3: send_read(a);
          default: begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            send_bad(b);
          end
        endcase
      end
      wait_quiet("rand");
      compare("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
